// File: rtl/lampfpu_sqrt_sched_pkg.sv
// Shared constants, FSM encoding and the result pack/round helper for the
// square-root sequencer.
package lampfpu_sqrt_sched_pkg;

    localparam logic [15:0] LAMP_QNAN       = 16'h7FC0;
    localparam logic [15:0] LAMP_PINF       = 16'h7F80;
    localparam logic [15:0] LAMP_NINF       = 16'hFF80;
    localparam int          LAMP_FLOAT_BIAS = 127;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, PACK, RESP} sqsched_state_t;

    // Normalise the Q1.15 unit result (value in [0.5,2)), round to nearest
    // even on 8 significand bits and repack as a positive bfloat16.
    // k is the halved unbiased input exponent (floor).
    function automatic logic [15:0] lamp_sqrt_pack(input logic [15:0]       res,
                                                   input logic signed [8:0] k,
                                                   input logic              inv);
        logic signed [9:0] kx;
        logic signed [9:0] ex;
        logic [7:0]        m;
        logic              g;
        logic              st;
        logic [8:0]        mr;
        kx = {k[8], k};
        ex = inv ? ($signed(10'(LAMP_FLOAT_BIAS)) - kx) : ($signed(10'(LAMP_FLOAT_BIAS)) + kx);
        if (res[15]) begin
            m  = res[15:8];
            g  = res[7];
            st = |res[6:0];
        end else begin
            m  = res[14:7];
            g  = res[6];
            st = |res[5:0];
            ex = ex - 10'sd1;
        end
        mr = {1'b0, m} + {8'b0, g & (st | m[0])};
        if (mr[8]) begin
            mr = 9'h080;
            ex = ex + 10'sd1;
        end
        return {1'b0, ex[7:0], mr[6:0]};
    endfunction

endpackage

// File: rtl/lampfpu_sqrt_sched_if.sv
// Requester / response bundle of the square-root sequencer.
//  req_valid/req_ready : per-requester handshake (ready is one-hot or zero)
//  req_op/req_inv      : bfloat16 operand (requester i at [16i+:16]) and 1/sqrt select
//  rsp_*               : single response channel carrying id, result and abort flag
// master = FPU issue side, slave = sequencer.
interface lampfpu_sqrt_sched_if #(
    parameter int NUM_REQ = 2
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*16-1:0] req_op;
    logic [NUM_REQ-1:0]    req_inv;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [15:0]           rsp_res;
    logic                  rsp_err;

    modport master (output req_valid, req_op, req_inv, rsp_ready,
                    input  req_ready, rsp_valid, rsp_id, rsp_res, rsp_err);
    modport slave  (input  req_valid, req_op, req_inv, rsp_ready,
                    output req_ready, rsp_valid, rsp_id, rsp_res, rsp_err);
endinterface

// File: rtl/lampfpu_rr_arbiter.sv
// Round-robin arbiter: grants the lowest requester at or after the pointer.
//  req_i     : request vector
//  adv_i     : commit strobe; when a grant exists the pointer moves past it
//  gnt_o     : one-hot grant (zero when no request)
//  gnt_idx_o : index of the granted requester
//  any_o     : at least one request present
module lampfpu_rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic                       adv_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx_o,
    output logic                       any_o
);
    localparam int IW = $clog2(NUM_REQ);

    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] cand;
    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IW'((int'(ptr_q) + i) % NUM_REQ);
            if (!found && req_i[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (adv_i && found)
            ptr_d = (idx == IW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

    assign gnt_o     = found ? (NUM_REQ'(1) << idx) : '0;
    assign gnt_idx_o = idx;
    assign any_o     = found;
endmodule

// File: rtl/lampfpu_sqrt_sched.sv
// Sequencer for the shared iterative square-root unit. Grants one requester
// at a time (round-robin), unpacks/classifies the bfloat16 operand, drives the
// unit, then rounds and repacks its Q1.15 result, with a watchdog on the wait.
//  clk, rst_n    : clock, asynchronous active-low reset
//  bus           : requester/response bundle (slave side)
//  sq_do_o       : one-cycle start pulse to the unit
//  sq_s_o        : significand 1.fffffff
//  sq_odd_o      : unbiased exponent is odd
//  sq_inv_o      : 1/sqrt select
//  sq_special_o  : special operand; unit returns without iterating
//  sq_valid_i    : unit result valid pulse
//  sq_res_i      : unit result, Q1.15
module lampfpu_sqrt_sched
    import lampfpu_sqrt_sched_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lampfpu_sqrt_sched_if.slave  bus,
    output logic                 sq_do_o,
    output logic [7:0]           sq_s_o,
    output logic                 sq_odd_o,
    output logic                 sq_inv_o,
    output logic                 sq_special_o,
    input  logic                 sq_valid_i,
    input  logic [15:0]          sq_res_i
);
    localparam int IDW  = $clog2(NUM_REQ);
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    sqsched_state_t state_q, state_d;
    logic [15:0]    op_q, op_d;
    logic           inv_q, inv_d;
    logic [IDW-1:0] id_q, id_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic [15:0]    raw_q, raw_d;
    logic [15:0]    res_q, res_d;
    logic           err_q, err_d;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [IDW-1:0]     arb_idx;
    logic               arb_any;

    logic signed [8:0] ue;
    logic signed [8:0] k;
    logic              special;
    logic [15:0]       sub;
    logic              timeout;
    logic              hold;

    lampfpu_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    (bus.req_valid),
        .adv_i    (state_q == IDLE),
        .gnt_o    (arb_gnt),
        .gnt_idx_o(arb_idx),
        .any_o    (arb_any)
    );

    // Unpack / classify the captured operand.
    assign ue      = $signed({1'b0, op_q[14:7]}) - $signed(9'(LAMP_FLOAT_BIAS));
    assign k       = ue >>> 1;
    assign special = (op_q[14:7] == 8'h00) | (op_q[14:7] == 8'hFF) | op_q[15];
    assign timeout = (wd_q == WD_W'(TIMEOUT_CYC - 1));

    // Substitute result for special operands; zero/denormal keeps its sign.
    always_comb begin
        sub = LAMP_QNAN;
        if (op_q[14:7] == 8'h00)
            sub = inv_q ? (op_q[15] ? LAMP_NINF : LAMP_PINF) : {op_q[15], 15'b0};
        else if (op_q[15] || (op_q[14:7] == 8'hFF && op_q[6:0] != 7'd0))
            sub = LAMP_QNAN;
        else if (op_q[14:7] == 8'hFF)
            sub = inv_q ? 16'h0000 : LAMP_PINF;
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (arb_any) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (sq_valid_i) state_d = PACK;
                     else if (timeout) state_d = RESP;
            PACK:    state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs. Unit-side fields are only driven while the op is in the unit.
    always_comb begin
        hold          = (state_q == ISSUE) || (state_q == WAIT);
        sq_do_o       = (state_q == ISSUE);
        sq_s_o        = hold ? {1'b1, op_q[6:0]} : 8'h00;
        sq_odd_o      = hold & ue[0];
        sq_inv_o      = hold & inv_q;
        sq_special_o  = hold & special;
        bus.req_ready = (state_q == IDLE) ? arb_gnt : '0;
        bus.rsp_valid = (state_q == RESP);
        bus.rsp_id    = (state_q == RESP) ? id_q  : '0;
        bus.rsp_res   = (state_q == RESP) ? res_q : 16'h0000;
        bus.rsp_err   = (state_q == RESP) & err_q;
    end

    // Datapath next state
    always_comb begin
        op_d  = op_q;
        inv_d = inv_q;
        id_d  = id_q;
        wd_d  = wd_q;
        raw_d = raw_q;
        res_d = res_q;
        err_d = err_q;
        unique case (state_q)
            IDLE: if (arb_any) begin
                op_d  = bus.req_op[{arb_idx, 4'b0000} +: 16];
                inv_d = bus.req_inv[arb_idx];
                id_d  = arb_idx;
            end
            ISSUE: wd_d = '0;
            WAIT: begin
                wd_d = wd_q + 1'b1;
                if (sq_valid_i) raw_d = sq_res_i;
                else if (timeout) begin
                    res_d = LAMP_QNAN;
                    err_d = 1'b1;
                end
            end
            PACK: begin
                res_d = special ? sub : lamp_sqrt_pack(raw_q, k, inv_q);
                err_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= '0;
            inv_q <= 1'b0;
            id_q  <= '0;
            wd_q  <= '0;
            raw_q <= '0;
            res_q <= '0;
            err_q <= 1'b0;
        end else begin
            op_q  <= op_d;
            inv_q <= inv_d;
            id_q  <= id_d;
            wd_q  <= wd_d;
            raw_q <= raw_d;
            res_q <= res_d;
            err_q <= err_d;
        end
    end
endmodule

// File: tb/tb_lampfpu_sqrt_sched.sv
module tb_lampfpu_sqrt_sched;
    localparam int NREQ    = 2;
    localparam int TIMEOUT = 64;

    logic        clk;
    logic        rst_n;
    logic        sq_do, sq_odd, sq_inv, sq_special, sq_valid;
    logic [7:0]  sq_s;
    logic [15:0] sq_res;

    lampfpu_sqrt_sched_if #(.NUM_REQ(NREQ)) bus();

    lampfpu_sqrt_sched #(.NUM_REQ(NREQ), .TIMEOUT_CYC(TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .sq_do_o     (sq_do),
        .sq_s_o      (sq_s),
        .sq_odd_o    (sq_odd),
        .sq_inv_o    (sq_inv),
        .sq_special_o(sq_special),
        .sq_valid_i  (sq_valid),
        .sq_res_i    (sq_res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Reference: value-level sqrt/rsqrt result from operand and unit output.
    function automatic logic [15:0] ref_result(input logic [15:0] op, input bit inv, input int unsigned res);
        int e, man, ue, k, ex, dv, q, r;
        bit neg;
        e   = (int'(op) / 128) % 256;
        man = int'(op) % 128;
        neg = (op >= 16'h8000);
        if (e == 0)   return inv ? (neg ? 16'hFF80 : 16'h7F80) : (neg ? 16'h8000 : 16'h0000);
        if (neg || (e == 255 && man != 0)) return 16'h7FC0;
        if (e == 255) return inv ? 16'h0000 : 16'h7F80;
        ue = e - 127;
        k  = (ue >= 0) ? ue / 2 : -((1 - ue) / 2);
        ex = inv ? 127 - k : 127 + k;
        if (res >= 32768) dv = 256;
        else begin dv = 128; ex = ex - 1; end
        q = int'(res) / dv;
        r = int'(res) % dv;
        if (2 * r > dv || (2 * r == dv && q % 2 == 1)) q = q + 1;
        if (q == 256) begin q = 128; ex = ex + 1; end
        return 16'(ex * 128 + (q - 128));
    endfunction

    function automatic bit ref_odd(input logic [15:0] op);
        int ue;
        ue = (int'(op) / 128) % 256 - 127;
        return (ue % 2) != 0;
    endfunction

    function automatic bit ref_special(input logic [15:0] op);
        int e;
        e = (int'(op) / 128) % 256;
        return (e == 0) || (e == 255) || (op >= 16'h8000);
    endfunction

    // Square-root unit stub
    int          stub_lat  = 1;
    bit          stub_mute = 0;
    logic [15:0] stub_res  = 16'h8000;
    logic [7:0]  cap_s;
    logic        cap_odd, cap_inv, cap_spec;
    int          do_tot = 0;

    initial begin
        sq_valid = 1'b0;
        sq_res   = 16'h0000;
        forever begin
            @(negedge clk);
            #1;
            if (sq_do) begin
                cap_s = sq_s; cap_odd = sq_odd; cap_inv = sq_inv; cap_spec = sq_special;
                if (!stub_mute) begin
                    repeat (stub_lat) @(negedge clk);
                    #1;
                    check("s_hold", 32'(sq_s), 32'(cap_s));
                    sq_valid = 1'b1;
                    sq_res   = stub_res;
                    @(negedge clk);
                    #1;
                    sq_valid = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (sq_do) do_tot++;
        if (bus.req_ready != '0) check("ready_onehot", 32'($countones(bus.req_ready)), 32'd1);
    end

    task automatic wait_grant(input int id);
        int t;
        t = 0;
        #1;
        while (bus.req_ready == '0 && t < 40) begin step(); t++; end
        check("grant", 32'(bus.req_ready), 32'(1 << id));
    endtask

    // Called in the cycle the grant is visible; follows the op to completion.
    task automatic finish_op(input int id, input logic [15:0] op, input bit inv,
                             input int hold, input bit keep);
        int t, d0, oth;
        logic [15:0] exp;
        oth = 1 - id;
        d0  = do_tot;
        step();
        if (!keep) bus.req_valid[id] = 1'b0;
        t = 1;
        while (!bus.rsp_valid && t < TIMEOUT + 30) begin step(); t++; end
        check("latency", t, stub_mute ? TIMEOUT + 2 : 3 + stub_lat);
        exp = stub_mute ? 16'h7FC0 : ref_result(op, inv, 32'(stub_res));
        check("res", 32'(bus.rsp_res), 32'(exp));
        check("id", 32'(bus.rsp_id), id);
        check("err", 32'(bus.rsp_err), 32'(stub_mute));
        check("do_pulses", do_tot - d0, 1);
        check("sq_s", 32'(cap_s), 32'(128 + op % 128));
        check("sq_odd", 32'(cap_odd), 32'(ref_odd(op)));
        check("sq_inv", 32'(cap_inv), 32'(inv));
        check("sq_special", 32'(cap_spec), 32'(ref_special(op)));
        if (!keep && hold > 0) bus.req_valid[oth] = 1'b1;
        for (int h = 0; h < hold; h++) begin
            step();
            check("hold_valid", 32'(bus.rsp_valid), 1);
            check("hold_res", 32'(bus.rsp_res), 32'(exp));
            check("hold_id", 32'(bus.rsp_id), id);
            check("hold_noready", 32'(bus.req_ready), 0);
        end
        bus.rsp_ready = 1'b1;
        check("no_grant_resp", 32'(bus.req_ready), 0);
        step();
        bus.rsp_ready = 1'b0;
        if (!keep && hold > 0) bus.req_valid[oth] = 1'b0;
        check("rsp_done", 32'(bus.rsp_valid), 0);
    endtask

    task automatic run_op(input int id, input logic [15:0] op, input bit inv,
                          input logic [15:0] res, input int lat, input int hold);
        stub_res = res;
        stub_lat = lat;
        bus.req_op[id*16 +: 16] = op;
        bus.req_inv[id]         = inv;
        bus.req_valid[id]       = 1'b1;
        wait_grant(id);
        finish_op(id, op, inv, hold, 1'b0);
    endtask

    int          d_id   [13] = '{0, 1, 0, 0, 1, 0, 1, 0, 1, 0, 0, 1, 0};
    logic [15:0] d_op   [13] = '{16'h4000, 16'h4080, 16'h0000, 16'h0000, 16'hBF80, 16'h7F80, 16'h7FC1,
                                 16'h4080, 16'h3F80, 16'h3F80, 16'h3F80, 16'h4000, 16'h8012};
    bit          d_inv  [13] = '{0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 1};
    logic [15:0] d_res  [13] = '{16'hB505, 16'h8000, 16'h1234, 16'h1234, 16'h8000, 16'h8000, 16'h8000,
                                 16'h8000, 16'hFFC0, 16'h8080, 16'h8180, 16'h5A82, 16'h8000};
    int          d_lat  [13] = '{2, 1, 1, 1, 1, 1, 1, 3, 1, 2, 1, 4, 1};
    int          d_hold [13] = '{0, 0, 0, 1, 0, 0, 0, 5, 0, 1, 0, 0, 2};

    initial begin
        logic [15:0] op;
        int id;
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_inv   = '0;
        bus.rsp_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) step();
        check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        check("rst_rsp_res", 32'(bus.rsp_res), 0);
        check("rst_sq_do", 32'(sq_do), 0);
        check("rst_sq_s", 32'(sq_s), 0);
        rst_n = 1'b1;
        step();

        // Both requesters held valid: grants must alternate 0,1,0,1.
        bus.req_op    = {16'h4080, 16'h4080};
        bus.req_inv   = 2'b10;
        stub_res      = 16'h8000;
        stub_lat      = 1;
        bus.req_valid = 2'b11;
        for (int g = 0; g < 4; g++) begin
            wait_grant(g % 2);
            finish_op(g % 2, 16'h4080, (g % 2) == 1, 0, 1'b1);
        end
        bus.req_valid = '0;
        step();

        for (int i = 0; i < 13; i++)
            run_op(d_id[i], d_op[i], d_inv[i], d_res[i], d_lat[i], d_hold[i]);

        for (int i = 0; i < 24; i++) begin
            id = int'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0) op = {1'b0, 8'($urandom_range(1, 254)), 7'($urandom)};
            else                           op = 16'($urandom);
            run_op(id, op, 1'($urandom), 16'($urandom_range(16'h4000, 16'hFFFF)),
                   int'($urandom_range(1, 4)), int'($urandom_range(0, 2)));
        end

        // Unit never answers: watchdog abort.
        stub_mute = 1'b1;
        run_op(1, 16'h4080, 1'b0, 16'h8000, 1, 1);

        // Reset asserted while the op sits in WAIT.
        bus.req_op[15:0] = 16'h4100;
        bus.req_inv[0]   = 1'b1;
        bus.req_valid[0] = 1'b1;
        wait_grant(0);
        step();
        bus.req_valid[0] = 1'b0;
        repeat (8) step();
        check("wait_sq_s", 32'(sq_s), 32'h80);
        check("wait_sq_inv", 32'(sq_inv), 1);
        rst_n = 1'b0;
        #1;
        check("midrst_sq_s", 32'(sq_s), 0);
        check("midrst_sq_inv", 32'(sq_inv), 0);
        check("midrst_sq_do", 32'(sq_do), 0);
        check("midrst_rsp_valid", 32'(bus.rsp_valid), 0);
        step();
        rst_n = 1'b1;
        stub_mute = 1'b0;
        step();

        // Pointer is back at 0 after reset.
        bus.req_op    = {16'h4080, 16'h4000};
        bus.req_inv   = 2'b00;
        stub_res      = 16'hB505;
        stub_lat      = 2;
        bus.req_valid = 2'b11;
        wait_grant(0);
        finish_op(0, 16'h4000, 1'b0, 0, 1'b0);
        bus.req_valid = '0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end
endmodule
